exec_stage: RTL and testbench
=============================

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of operands and result.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-low.
REQ-004 in_valid  in  1  ID/EX register presents a valid instruction this cycle.
REQ-005 OpCode  in  5  operation code from ID/EX register.
REQ-006 Rd  in  WIDTH  destination tag, passed through unchanged.
REQ-007 Rs  in  WIDTH  first operand.
REQ-008 Rt  in  WIDTH  second operand.
REQ-009 Rsi  in  WIDTH  immediate operand.
REQ-010 flush  in  1  discard the current instruction and any multiply in progress.
REQ-011 stall  out  1  combinational; high means the ID/EX register shall hold its contents.
REQ-012 out_valid  out  1  registered; Result/RdOut/OpCodeOut/Zero carry a new result this cycle.
REQ-013 OpCodeOut  out  5  opcode of the completed instruction.
REQ-014 RdOut  out  WIDTH  Rd of the completed instruction.
REQ-015 Result  out  WIDTH  execution result.
REQ-016 Zero  out  1  high when Result equals 0.

Function
REQ-017 Opcode map: 0 NOP; 1 ADD Rs+Rt; 2 SUB Rs-Rt; 3 AND; 4 OR; 5 XOR; 6 SLL Rs<<Rt[4:0]; 7 SRL Rs>>Rt[4:0] (logical); 8 ADDI Rs+Rsi; 9 MUL Rs*Rt; 10 MOVI Rsi; 11-31 treated as NOP.
REQ-018 All arithmetic is modulo 2^WIDTH; carries, borrows and upper product bits are discarded.
REQ-019 FSM states: RUN and MUL; reset state is RUN.
REQ-020 In RUN, an instruction is accepted when in_valid=1 and flush=0.
REQ-021 An accepted single-cycle op (1-8, 10) updates Result, RdOut, OpCodeOut and Zero at the next edge, with out_valid=1 for exactly that following cycle.
REQ-022 An accepted NOP or unused opcode produces out_valid=0 and leaves the result outputs unchanged.
REQ-023 When MUL is accepted in RUN, stall=1 in the acceptance cycle, and at the next edge the FSM latches Rs and Rt, clears the accumulator and iteration counter, and enters MUL.
REQ-024 In MUL, each cycle performs one shift-add iteration on the latched operands and ignores the ID/EX inputs; 32 iterations are performed (counter 0..31).
REQ-025 In MUL, stall=1 while counter<31 and stall=0 in the counter=31 cycle, so stall is high for exactly 32 consecutive cycles per MUL.
REQ-026 At the edge ending the counter=31 cycle, the FSM writes the low WIDTH product bits to Result with out_valid=1, returns to RUN, and accepts no new instruction in that cycle.
REQ-027 MUL latency: out_valid for the MUL is high 33 cycles after the acceptance cycle.
REQ-028 out_valid is 0 in every cycle not specified by REQ-021 or REQ-026.
REQ-029 Result, RdOut, OpCodeOut and Zero hold their last values whenever out_valid=0.
REQ-030 If flush=1 in RUN, the presented instruction is dropped, and out_valid=0 and stall=0 in that cycle.
REQ-031 If flush=1 in MUL, the multiply is aborted, stall=0 in that cycle, the FSM is in RUN at the next edge, and no out_valid is produced.
REQ-032 If flush and in_valid are both high, flush wins.
REQ-033 Zero is registered together with Result and reflects the same value.

Reset
REQ-034 While rst=0 at a rising edge, the FSM goes to RUN and out_valid, Result, RdOut, OpCodeOut, Zero, the accumulator and the counter are cleared to 0.
REQ-035 While rst=0, stall=0.
REQ-036 Reset asserted mid-MUL aborts the multiply with no result emitted.

Verification
REQ-037 ADD, Rs=5, Rt=7, Rd=1 -> next cycle out_valid=1, Result=12, RdOut=1, OpCodeOut=1, Zero=0.
REQ-038 SUB, Rs=3, Rt=3, then ADDI, Rs=0xFFFFFFFF, Rsi=1, back-to-back -> two consecutive out_valid cycles, Result=0 with Zero=1 each time.
REQ-039 MUL, Rs=6, Rt=7 -> stall high for 32 cycles starting at acceptance, out_valid=1 with Result=42 exactly 33 cycles after acceptance, and the next instruction is accepted in the cycle after the result.
REQ-040 MUL, Rs=0xFFFFFFFF, Rt=2 -> Result=0xFFFFFFFE (wrap-around).
REQ-041 MUL, then flush at counter=10 -> stall=0 in that cycle, no out_valid, and an ADD presented next completes normally.
REQ-042 MUL, then rst=0 at counter=20 -> all outputs are 0 next cycle, stall=0, and no MUL result appears after release.

Source files
------------

// File: rtl/exec_if.sv
// ID/EX to execute-stage bus: instruction fields in, stall and completed result out.
interface exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [4:0]       OpCode;
    logic [WIDTH-1:0] Rd;
    logic [WIDTH-1:0] Rs;
    logic [WIDTH-1:0] Rt;
    logic [WIDTH-1:0] Rsi;
    logic             flush;
    logic             stall;
    logic             out_valid;
    logic [4:0]       OpCodeOut;
    logic [WIDTH-1:0] RdOut;
    logic [WIDTH-1:0] Result;
    logic             Zero;

    // Decode/ID-EX side: presents instructions, honours stall, consumes results.
    modport master (
        output in_valid, OpCode, Rd, Rs, Rt, Rsi, flush,
        input  stall, out_valid, OpCodeOut, RdOut, Result, Zero
    );

    // Execute-stage side.
    modport slave (
        input  in_valid, OpCode, Rd, Rs, Rt, Rsi, flush,
        output stall, out_valid, OpCodeOut, RdOut, Result, Zero
    );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus a serial shift-add multiplier that
// stalls the ID/EX register for the duration of the multiply.
module exec_stage #(
    parameter int WIDTH = 32
) (
    input logic   clk,
    input logic   rst,
    exec_if.slave bus
);
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SLL  = 5'd6;
    localparam logic [4:0] OP_SRL  = 5'd7;
    localparam logic [4:0] OP_ADDI = 5'd8;
    localparam logic [4:0] OP_MUL  = 5'd9;
    localparam logic [4:0] OP_MOVI = 5'd10;

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        RUN = 1'b0,
        MUL = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic             stall;

    logic [WIDTH-1:0] alu_result;
    logic             alu_writes;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mul_rd;
    logic [CNT_W-1:0] cnt;

    logic             out_valid;
    logic [4:0]       opcode_out;
    logic [WIDTH-1:0] rd_out;
    logic [WIDTH-1:0] result;
    logic             zero;

    // Next-state and handshake decode; reset overrides everything so stall stays low.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        state_next = state;
        accept     = 1'b0;
        mul_start  = 1'b0;
        mul_done   = 1'b0;
        stall      = 1'b0;
        case (state)
            RUN: begin
                accept = bus.in_valid && !bus.flush;
                if (accept && bus.OpCode == OP_MUL) begin
                    stall      = 1'b1;
                    mul_start  = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                if (bus.flush) begin
                    state_next = RUN;
                end else if (cnt == CNT_LAST) begin
                    mul_done   = 1'b1;
                    state_next = RUN;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
        if (!rst) begin
            state_next = RUN;
            accept     = 1'b0;
            mul_start  = 1'b0;
            mul_done   = 1'b0;
            stall      = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Single-cycle ALU; alu_writes flags the opcodes that produce a result this way.
    always_comb begin
        alu_result = '0;
        alu_writes = 1'b1;
        case (bus.OpCode)
            OP_ADD:  alu_result = bus.Rs + bus.Rt;
            OP_SUB:  alu_result = bus.Rs - bus.Rt;
            OP_AND:  alu_result = bus.Rs & bus.Rt;
            OP_OR:   alu_result = bus.Rs | bus.Rt;
            OP_XOR:  alu_result = bus.Rs ^ bus.Rt;
            OP_SLL:  alu_result = bus.Rs << bus.Rt[4:0];
            OP_SRL:  alu_result = bus.Rs >> bus.Rt[4:0];
            OP_ADDI: alu_result = bus.Rs + bus.Rsi;
            OP_MOVI: alu_result = bus.Rsi;
            default: alu_writes = 1'b0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    // Multiplier datapath: load operands on acceptance, then iterate once per MUL cycle.
    always_ff @(posedge clk) begin
        // NOTE: only the multiplier state with a defined reset value is cleared; no memories exist here.
        if (!rst) begin
            acc    <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            mul_rd <= '0;
        end else if (mul_start) begin
            acc    <= '0;
            cnt    <= '0;
            mcand  <= bus.Rs;
            mplier <= bus.Rt;
            mul_rd <= bus.Rd;
        end else if (state == MUL) begin
            acc    <= acc_next;
            cnt    <= cnt + CNT_W'(1);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Result registers: load from the multiplier on its last step or from the ALU on acceptance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            opcode_out <= '0;
            rd_out     <= '0;
            result     <= '0;
            zero       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (mul_done) begin
                out_valid  <= 1'b1;
                opcode_out <= OP_MUL;
                rd_out     <= mul_rd;
                result     <= acc_next;
                zero       <= (acc_next == '0);
            end else if (accept && alu_writes) begin
                out_valid  <= 1'b1;
                opcode_out <= bus.OpCode;
                rd_out     <= bus.Rd;
                result     <= alu_result;
                zero       <= (alu_result == '0);
            end
        end
    end

    assign bus.stall     = stall;
    assign bus.out_valid = out_valid;
    assign bus.OpCodeOut = opcode_out;
    assign bus.RdOut     = rd_out;
    assign bus.Result    = result;
    assign bus.Zero      = zero;
endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: scoreboard queue of expected results
// drained by a negedge monitor, plus per-scenario timing checks.
module tb_exec_stage;
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SLL  = 5'd6;
    localparam logic [4:0] OP_SRL  = 5'd7;
    localparam logic [4:0] OP_ADDI = 5'd8;
    localparam logic [4:0] OP_MUL  = 5'd9;
    localparam logic [4:0] OP_MOVI = 5'd10;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] rd;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    exec_if #(.WIDTH(32)) bus ();

    exec_stage #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Reference result for one instruction, written from the opcode table.
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [31:0] rsi);
        logic [63:0] p;
        case (op)
            OP_ADD:  return rs + rt;
            OP_SUB:  return rs - rt;
            OP_AND:  return rs & rt;
            OP_OR:   return rs | rt;
            OP_XOR:  return rs ^ rt;
            OP_SLL:  return rs << rt[4:0];
            OP_SRL:  return rs >> rt[4:0];
            OP_ADDI: return rs + rsi;
            OP_MOVI: return rsi;
            OP_MUL: begin
                p = 64'(rs) * 64'(rt);
                return p[31:0];
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic push(input logic [4:0] op, input logic [31:0] rd, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] rsi);
        exp_t e;
        e.op   = op;
        e.rd   = rd;
        e.res  = model(op, rs, rt, rsi);
        e.zero = (e.res == 32'h0);
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] rd,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] rsi,
                         input logic fl);
        bus.in_valid = v;
        bus.OpCode   = op;
        bus.Rd       = rd;
        bus.Rs       = rs;
        bus.Rt       = rt;
        bus.Rsi      = rsi;
        bus.flush    = fl;
    endtask

    task automatic idle();
        drive(1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every out_valid outside reset must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && bus.out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out_valid got op=%0d rd=%0h res=%0h required no result",
                         bus.OpCodeOut, bus.RdOut, bus.Result);
            end else begin
                e = sb.pop_front();
                if ({bus.OpCodeOut, bus.RdOut, bus.Result, bus.Zero} !== {e.op, e.rd, e.res, e.zero}) begin
                    failures++;
                    $display("FAIL result got op=%0d rd=%0h res=%0h zero=%0b required op=%0d rd=%0h res=%0h zero=%0b",
                             bus.OpCodeOut, bus.RdOut, bus.Result, bus.Zero, e.op, e.rd, e.res, e.zero);
                end
            end
        end
    end

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL %s_pending got %0d outstanding results required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, OP_MUL, 32'h9, 32'h6, 32'h7, 32'h0, 1'b0);
        step();
        step();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b required 0", bus.out_valid); end
        checks++;
        if (bus.Result !== 32'h0) begin failures++; $display("FAIL reset_result got %0h required 0", bus.Result); end
        checks++;
        if (bus.RdOut !== 32'h0) begin failures++; $display("FAIL reset_rdout got %0h required 0", bus.RdOut); end
        checks++;
        if (bus.OpCodeOut !== 5'h0) begin failures++; $display("FAIL reset_opcodeout got %0h required 0", bus.OpCodeOut); end
        checks++;
        if (bus.Zero !== 1'b0) begin failures++; $display("FAIL reset_zero got %0b required 0", bus.Zero); end
        checks++;
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got %0b required 0", bus.stall); end
        step();
        rst = 1'b1;
        idle();
        step();
    endtask

    task automatic test_add();
        drive(1'b1, OP_ADD, 32'h1, 32'd5, 32'd7, 32'h0, 1'b0);
        push(OP_ADD, 32'h1, 32'd5, 32'd7, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL add_stall got %0b required 0", bus.stall); end
        step();
        idle();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_latency got out_valid=%0b required 1", bus.out_valid); end
        step();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.Result !== 32'd12) begin
            failures++;
            $display("FAIL add_hold got out_valid=%0b res=%0h required out_valid=0 res=c", bus.out_valid, bus.Result);
        end
        step();
        check_drained("add");
    endtask

    task automatic test_back_to_back();
        drive(1'b1, OP_SUB, 32'h2, 32'd3, 32'd3, 32'h0, 1'b0);
        push(OP_SUB, 32'h2, 32'd3, 32'd3, 32'h0);
        step();
        drive(1'b1, OP_ADDI, 32'h3, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        push(OP_ADDI, 32'h3, 32'hFFFF_FFFF, 32'h0, 32'h1);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_first got out_valid=%0b required 1", bus.out_valid); end
        step();
        idle();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_second got out_valid=%0b required 1", bus.out_valid); end
        step();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_after got out_valid=%0b required 0", bus.out_valid); end
        step();
        check_drained("b2b");
    endtask

    task automatic test_alu_ops();
        logic [4:0]  ops [8] = '{OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SUB, OP_ADDI, OP_MOVI};
        logic [31:0] rs, rt, rsi;
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 8; i++) begin
                rs  = $urandom();
                rt  = (rep == 0 && (ops[i] == OP_SLL || ops[i] == OP_SRL)) ? 32'd31 : $urandom();
                rsi = $urandom();
                drive(1'b1, ops[i], 32'(100 + i), rs, rt, rsi, 1'b0);
                push(ops[i], 32'(100 + i), rs, rt, rsi);
                step();
            end
        end
        idle();
        step();
        step();
        check_drained("alu_ops");
    endtask

    task automatic test_nop();
        logic [4:0] nops [3] = '{OP_NOP, 5'd31, 5'd11};
        drive(1'b1, OP_MOVI, 32'h4, 32'h0, 32'h0, 32'h1234, 1'b0);
        push(OP_MOVI, 32'h4, 32'h0, 32'h0, 32'h1234);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, nops[i], 32'h9, 32'h5, 32'h5, 32'h5, 1'b0);
            step();
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.Result !== 32'h1234 || bus.RdOut !== 32'h4 || bus.OpCodeOut !== OP_MOVI) begin
                failures++;
                $display("FAIL nop_%0d got out_valid=%0b res=%0h rd=%0h op=%0d required 0/1234/4/10",
                         nops[i], bus.out_valid, bus.Result, bus.RdOut, bus.OpCodeOut);
            end
        end
        idle();
        step();
        check_drained("nop");
    endtask

    // MUL held in ID/EX while stalled, followed by an ADD once the result is out.
    task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] rd);
        logic [35:0] st;
        logic [35:0] ov;
        logic [35:0] exp_st;
        logic [35:0] exp_ov;
        st = '0;
        ov = '0;
        exp_st = 36'h0_FFFF_FFFF;
        exp_ov = (36'h1 << 33) | (36'h1 << 34);
        for (int k = 0; k < 36; k++) begin
            if (k <= 32) begin
                drive(1'b1, OP_MUL, rd, a, b, 32'h0, 1'b0);
                if (k == 0) push(OP_MUL, rd, a, b, 32'h0);
            end else if (k == 33) begin
                drive(1'b1, OP_ADD, rd + 1, a, 32'h1, 32'h0, 1'b0);
                push(OP_ADD, rd + 1, a, 32'h1, 32'h0);
            end else begin
                idle();
            end
            @(negedge clk);
            st[k] = bus.stall;
            ov[k] = bus.out_valid;
            step();
        end
        checks++;
        if (st !== exp_st) begin failures++; $display("FAIL mul_stall_window got %h required %h", st, exp_st); end
        checks++;
        if (ov !== exp_ov) begin failures++; $display("FAIL mul_out_valid_timing got %h required %h", ov, exp_ov); end
        check_drained("mul");
    endtask

    task automatic test_mul_flush();
        logic [15:0] st;
        logic [15:0] ov;
        st = '0;
        ov = '0;
        for (int k = 0; k < 16; k++) begin
            if (k <= 10)       drive(1'b1, OP_MUL, 32'h7, 32'd6, 32'd7, 32'h0, 1'b0);
            else if (k == 11)  drive(1'b1, OP_MUL, 32'h7, 32'd6, 32'd7, 32'h0, 1'b1);
            else if (k == 12) begin
                drive(1'b1, OP_ADD, 32'h5, 32'd10, 32'd20, 32'h0, 1'b0);
                push(OP_ADD, 32'h5, 32'd10, 32'd20, 32'h0);
            end else idle();
            @(negedge clk);
            st[k] = bus.stall;
            ov[k] = bus.out_valid;
            step();
        end
        checks++;
        if (st !== 16'h07FF) begin failures++; $display("FAIL flush_stall got %h required 07ff", st); end
        checks++;
        if (ov !== 16'h2000) begin failures++; $display("FAIL flush_out_valid got %h required 2000", ov); end
        check_drained("flush");
    endtask

    task automatic test_mul_reset();
        logic [63:0] st;
        logic [63:0] ov;
        st = '0;
        ov = '0;
        for (int k = 0; k < 64; k++) begin
            rst = (k == 21) ? 1'b0 : 1'b1;
            if (k <= 21) drive(1'b1, OP_MUL, 32'h8, 32'd3, 32'd5, 32'h0, 1'b0);
            else idle();
            @(negedge clk);
            st[k] = bus.stall;
            ov[k] = bus.out_valid;
            if (k == 22) begin
                checks++;
                if ({bus.out_valid, bus.Result, bus.RdOut, bus.OpCodeOut, bus.Zero} !== '0) begin
                    failures++;
                    $display("FAIL mulrst_clear got out_valid=%0b res=%0h rd=%0h op=%0d zero=%0b required all 0",
                             bus.out_valid, bus.Result, bus.RdOut, bus.OpCodeOut, bus.Zero);
                end
            end
            step();
        end
        checks++;
        if (st !== 64'h1F_FFFF) begin failures++; $display("FAIL mulrst_stall got %h required 1fffff", st); end
        checks++;
        if (ov !== 64'h0) begin failures++; $display("FAIL mulrst_out_valid got %h required 0", ov); end
        check_drained("mulrst");
    endtask

    initial begin
        idle();
        test_reset();
        test_add();
        test_back_to_back();
        test_alu_ops();
        test_nop();
        test_mul(32'd6, 32'd7, 32'h11);
        test_mul(32'hFFFF_FFFF, 32'd2, 32'h12);
        test_mul($urandom(), $urandom(), 32'h13);
        test_mul_flush();
        test_mul_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
